// File: rtl/vlc_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : vlc_packer_if
// Purpose  : Bundles the code-input and packed-word-output handshakes of the
//            variable-length-code packer.
// Signals  : code        [CODE_W]  right-aligned code bits
//            length      [LEN_W]   number of valid code bits (0 = no-op)
//            flush                 request emission of the partial word
//            in_ready              packer can take code/length/flush
//            encoded_out [OUT_W]   packed word, MSB-first, zero-padded
//            last_bits   [LB_W]    valid bits in encoded_out
//            enable_out            encoded_out valid, held until accepted
//            out_ready             consumer takes the word
// Modports : slave  - the packer itself
//            master - the producer/consumer environment around it
// Revision : 1.0  initial release
// ============================================================================
interface vlc_packer_if #(
    parameter int CODE_W = 8,
    parameter int LEN_W  = 4,
    parameter int OUT_W  = 32
);
    localparam int c_LB_W = LEN_W + $clog2(OUT_W + 1);

    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  length;
    logic              flush;
    logic              in_ready;
    logic [OUT_W-1:0]  encoded_out;
    logic [c_LB_W-1:0] last_bits;
    logic              enable_out;
    logic              out_ready;

    modport slave (
        input  code, length, flush, out_ready,
        output in_ready, encoded_out, last_bits, enable_out
    );

    modport master (
        output code, length, flush, out_ready,
        input  in_ready, encoded_out, last_bits, enable_out
    );
endinterface
`default_nettype wire

// File: rtl/vlc_packer.sv
`default_nettype none
// ============================================================================
// Module   : vlc_packer
// Purpose  : Packs variable-length codes MSB-first into OUT_W-bit words.
//            Codes are appended directly below the bits already buffered; a
//            full word is emitted through a one-deep output register, and a
//            flush emits the partial word left-aligned and zero-padded.
// Ports    : clock   - rising-edge clock
//            resetn  - asynchronous active-low reset
//            ce      - clock enable, 0 freezes all state and both handshakes
//            bus     - vlc_packer_if.slave (code/length/flush/in_ready,
//                      encoded_out/last_bits/enable_out/out_ready)
//            word_count [32] - output handshake counter (only when the
//                      VLC_PACKER_STATS_EN macro is defined)
// Options  : VLC_PACKER_STATS_EN - adds the word_count port and counter
// Revision : 1.0  initial release
// ============================================================================
module vlc_packer #(
    parameter int CODE_W = 8,
    parameter int LEN_W  = 4,
    parameter int OUT_W  = 32
) (
    input  wire logic clock,
    input  wire logic resetn,
    input  wire logic ce,
    vlc_packer_if.slave bus
`ifdef VLC_PACKER_STATS_EN
    ,
    output logic [31:0] word_count
`endif
);

    // Worst case the accumulator holds OUT_W-1 bits plus one full code.
    localparam int c_ACC_W = OUT_W + CODE_W - 1;
    localparam int c_CNT_W = $clog2(c_ACC_W + 1);
    localparam int c_LB_W  = LEN_W + $clog2(OUT_W + 1);

    localparam logic [1:0] c_ST_PACK  = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    localparam logic [c_CNT_W-1:0] c_OUT_W_CNT = c_CNT_W'(OUT_W);
    localparam logic [c_CNT_W-1:0] c_ACC_W_CNT = c_CNT_W'(c_ACC_W);

    // State registers
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_ACC_W-1:0] r_acc;
    logic               r_flush_pend;
    logic [OUT_W-1:0]   r_word;
    logic [c_LB_W-1:0]  r_bits;
    logic               r_valid;

    // Next-state values
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_ACC_W-1:0] w_acc_nxt;
    logic               w_fp_nxt;
    logic [OUT_W-1:0]   w_word_nxt;
    logic [c_LB_W-1:0]  w_bits_nxt;
    logic               w_valid_nxt;

    // Append datapath
    logic [LEN_W-1:0]   w_len_eff;
    logic [CODE_W-1:0]  w_mask;
    logic [CODE_W-1:0]  w_code_m;
    logic [c_CNT_W-1:0] w_shamt;
    logic [c_CNT_W-1:0] w_new_cnt;
    logic [c_ACC_W-1:0] w_acc_app;
    logic               w_accept;
    logic               w_out_free;

    assign bus.in_ready   = ce & (r_cnt < c_OUT_W_CNT) & (r_state == c_ST_PACK);
    assign bus.encoded_out = r_word;
    assign bus.last_bits   = r_bits;
    assign bus.enable_out  = r_valid;

    // in_ready already contains ce and the PACK state, so an accept can only
    // happen while packing.
    assign w_accept   = bus.in_ready;
    // The output register can be reloaded when empty or when its current
    // word leaves on this same edge.
    assign w_out_free = ~r_valid | bus.out_ready;

    always_comb begin
        w_len_eff = bus.length;
        if (bus.length > LEN_W'(CODE_W)) begin
            w_len_eff = LEN_W'(CODE_W);
        end
        // Shifting an all-ones vector by >= CODE_W yields zero, so a full
        // length produces an all-ones mask without a special case.
        w_mask    = ~({CODE_W{1'b1}} << w_len_eff);
        w_code_m  = bus.code & w_mask;
        w_new_cnt = r_cnt + c_CNT_W'(w_len_eff);
        // Place the code MSB just below the last valid bit. Only used in PACK
        // where r_cnt < OUT_W, so this never underflows.
        w_shamt   = c_ACC_W_CNT - r_cnt - c_CNT_W'(w_len_eff);
        // Bits below r_cnt are always zero, so OR-ing is a clean append.
        w_acc_app = r_acc | (c_ACC_W'(w_code_m) << w_shamt);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_fp_nxt    = r_flush_pend;
        w_word_nxt  = r_word;
        w_bits_nxt  = r_bits;
        w_valid_nxt = r_valid & ~bus.out_ready;

        case (r_state)
            c_ST_PACK: begin
                if (w_accept) begin
                    w_acc_nxt = w_acc_app;
                    w_cnt_nxt = w_new_cnt;
                    if (w_new_cnt >= c_OUT_W_CNT) begin
                        // Word complete; a flush on the same edge must wait
                        // until the full word has been drained.
                        w_state_nxt = c_ST_DRAIN;
                        w_fp_nxt    = bus.flush;
                    end else if (bus.flush && (w_new_cnt != '0)) begin
                        w_state_nxt = c_ST_FLUSH;
                    end
                end
            end

            c_ST_DRAIN: begin
                if (w_out_free) begin
                    w_word_nxt  = r_acc[c_ACC_W-1 -: OUT_W];
                    w_bits_nxt  = c_LB_W'(OUT_W);
                    w_valid_nxt = 1'b1;
                    w_acc_nxt   = r_acc << OUT_W;
                    w_cnt_nxt   = r_cnt - c_OUT_W_CNT;
                    w_fp_nxt    = 1'b0;
                    // A pending flush with nothing left over is already
                    // satisfied by the word just emitted.
                    if (r_flush_pend && (w_cnt_nxt != '0)) begin
                        w_state_nxt = c_ST_FLUSH;
                    end else begin
                        w_state_nxt = c_ST_PACK;
                    end
                end
            end

            c_ST_FLUSH: begin
                if (w_out_free) begin
                    w_word_nxt  = r_acc[c_ACC_W-1 -: OUT_W];
                    w_bits_nxt  = c_LB_W'(r_cnt);
                    w_valid_nxt = 1'b1;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_PACK;
                end
            end

            default: begin
                w_state_nxt = c_ST_PACK;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_ST_PACK;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_flush_pend <= 1'b0;
            r_word       <= '0;
            r_bits       <= '0;
            r_valid      <= 1'b0;
        end else if (ce) begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_acc        <= w_acc_nxt;
            r_flush_pend <= w_fp_nxt;
            r_word       <= w_word_nxt;
            r_bits       <= w_bits_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

`ifdef VLC_PACKER_STATS_EN
    logic        w_handshake;
    logic [31:0] r_word_count;

    assign w_handshake = ce & r_valid & bus.out_ready;
    assign word_count  = r_word_count;

    // Free-running, wraps naturally at 2**32.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_word_count <= '0;
        end else if (w_handshake) begin
            r_word_count <= r_word_count + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/vlc_packer.md
VLC_PACKER -- requirements
Module: vlc_packer

Interface
REQ-001 Parameter CODE_W, default 8, maximum code width in bits.
REQ-002 Parameter LEN_W, default 4, width of length port; 2**LEN_W > CODE_W.
REQ-003 Parameter OUT_W, default 32, output word width; OUT_W >= CODE_W.
REQ-004 clock  input  1  rising-edge clock, sole clock domain.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 ce  input  1  clock enable; 0 freezes all state, no transfers either side.
REQ-007 code  input  CODE_W  code bits, right-aligned, bits at or above length ignored.
REQ-008 length  input  LEN_W  valid code bits; 0 = no-op.
REQ-009 flush  input  1  request emission of partial word.
REQ-010 in_ready  output  1  code/length/flush accepted on an edge where ce=1 and in_ready=1.
REQ-011 encoded_out  output  OUT_W  packed word, MSB-first, zero-padded.
REQ-012 last_bits  output  LEN_W+ceil(log2(OUT_W+1))  valid bits in encoded_out (OUT_W for full words).
REQ-013 enable_out  output  1  encoded_out valid; held until accepted.
REQ-014 out_ready  input  1  consumer accepts word on edge with ce=1, enable_out=1, out_ready=1.

Function
REQ-015 Accumulator of OUT_W+CODE_W-1 bits plus counter cnt; new code appended immediately below existing bits.
REQ-016 length > CODE_W shall be clamped to CODE_W; length=0 accepted without changing state.
REQ-017 in_ready = ce & (cnt < OUT_W) & (state == PACK).
REQ-018 FSM states PACK, DRAIN, FLUSH; PACK->DRAIN when accept makes cnt >= OUT_W; PACK->FLUSH when flush accepted with post-append cnt in 1..OUT_W-1; flush with cnt=0 ignored.
REQ-019 Code and flush may be accepted on the same edge; code appended first, then flush evaluated on the new cnt.
REQ-020 DRAIN: when output register free (enable_out=0 or being accepted), top OUT_W bits move to encoded_out, last_bits=OUT_W, cnt-=OUT_W, remainder shifted up; return to PACK (or FLUSH if a flush was pending and remainder > 0).
REQ-021 FLUSH: when output register free, left-aligned partial word zero-padded to encoded_out, last_bits=cnt, cnt=0, -> PACK.
REQ-022 Latency: word completed by accept at edge k appears with enable_out=1 after edge k+1 if output register free.
REQ-023 enable_out/encoded_out/last_bits stable while enable_out=1 and out_ready=0; no word ever dropped or duplicated.
REQ-024 Same-edge output accept and reload allowed: full throughput one word per two input-stall-free cycles minimum.
REQ-025 Pending flush request latched (flush_pend) if flush accepted while transition goes to DRAIN.

Reset
REQ-026 resetn=0 asynchronously: state=PACK, cnt=0, accumulator=0, flush_pend=0, encoded_out=0, last_bits=0, enable_out=0; in_ready follows REQ-017.
REQ-027 Reset mid-word or mid-handshake discards all buffered bits; first accept after release starts a new word at MSB.

Configuration
REQ-028 Macro VLC_PACKER_STATS_EN defined: extra output word_count (32 bits) increments on each output handshake, wraps 2**32-1 -> 0, reset 0.
REQ-029 Macro undefined: port word_count and its counter absent; all other behaviour identical.

Verification
REQ-030 16 accepts code=8'h02 length=2, out_ready=1 -> encoded_out=32'hAAAAAAAA, last_bits=32, enable_out one cycle after 16th accept.
REQ-031 codes 8'hF1..8'hF8 length=4 -> encoded_out=32'h12345678 (upper code bits ignored).
REQ-032 out_ready=0, 18 accepts code=8'hFF length=4 (72 bits) -> first word 32'hFFFFFFFF held, in_ready=0 after 64 bits; release out_ready -> two words then 8 bits remain, cnt=8.
REQ-033 codes 8'h0A,8'h0B,8'h0C length=4, flush on third -> encoded_out=32'hABC00000, last_bits=12, next word starts fresh.
REQ-034 length=0 repeated -> no state change; length=9 code=8'hFF -> treated as 8 bits.
REQ-035 resetn pulse after 20 bits, no flush -> enable_out=0, following 32 bits of 8'h55/length 8 -> 32'h55555555 only; with VLC_PACKER_STATS_EN, word_count=1.
